// File: rtl/ihex_record_parser_if.sv
// Bundle of the UART byte stream, the status transmitter, the Wishbone write master
// and the status pulses that connect ihex_record_parser to the rest of the system.
interface ihex_record_parser_if;
    logic        i_rx_stb;
    logic [7:0]  i_rx_data;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    logic        o_mwb_cyc;
    logic        o_mwb_stb;
    logic        o_mwb_we;
    logic [3:0]  o_mwb_sel;
    logic [29:0] o_mwb_addr;
    logic [31:0] o_mwb_data;
    logic        i_mwb_stall;
    logic        i_mwb_ack;
    logic        i_mwb_err;
    logic        o_eof;
    logic        o_overrun;
    logic [3:0]  dbg_state;

    // Parser side.
    modport master (
        input  i_rx_stb, i_rx_data, i_tx_busy, i_mwb_stall, i_mwb_ack, i_mwb_err,
        output o_tx_stb, o_tx_data, o_mwb_cyc, o_mwb_stb, o_mwb_we, o_mwb_sel,
        output o_mwb_addr, o_mwb_data, o_eof, o_overrun, dbg_state
    );

    // UART / bus / observer side.
    modport slave (
        output i_rx_stb, i_rx_data, i_tx_busy, i_mwb_stall, i_mwb_ack, i_mwb_err,
        input  o_tx_stb, o_tx_data, o_mwb_cyc, o_mwb_stb, o_mwb_we, o_mwb_sel,
        input  o_mwb_addr, o_mwb_data, o_eof, o_overrun, dbg_state
    );
endinterface

// File: rtl/ihex_record_parser.sv
// Intel-HEX record parser: decodes ASCII records from the UART, validates the checksum,
// commits data records as 32-bit Wishbone writes and answers with one status character.
module ihex_record_parser #(
    parameter int MAX_BYTES  = 16,
    parameter int WB_TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    ihex_record_parser_if.master  bus
);
    // Handshakes: rx and tx are single-cycle strobes (tx only while i_tx_busy is low);
    // a WB request is taken on a cycle with cyc & stb & !stall, then exactly one ack/err
    // (err wins when both are high) closes it while cyc stays high.

    localparam int TW = $clog2(WB_TIMEOUT) + 1;
    localparam int BI = $clog2(MAX_BYTES);
    localparam int WB = (MAX_BYTES > 4) ? $clog2(MAX_BYTES / 4) : 1;

    localparam logic [7:0] CH_K = 8'h4B;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_T = 8'h54;

    typedef enum logic [3:0] {
        S_IDLE, S_COUNT, S_ADDR, S_TYPE, S_DATA, S_CSUM, S_WB_REQ, S_WB_WAIT, S_RESP
    } state_t;

    state_t state, state_next;

    logic [7:0]             csum;
    logic [15:0]            ext_addr;
    logic                   have_hi;
    logic [3:0]             hi_nib;
    logic [7:0]             count;
    logic [15:0]            rec_addr;
    logic [7:0]             rec_type;
    logic [7:0]             field_idx;
    logic [5:0]             word_idx;
    logic [TW-1:0]          timer;
    logic [MAX_BYTES*8-1:0] data_buf;
    logic [7:0]             resp_char;
    logic [7:0]             resp_next;
    logic                   eof_q;
    logic                   overrun_q;

    logic       is_hex;
    logic [3:0] nib;
    logic       parse_state;
    logic       rx_colon;
    logic       bad_char;
    logic       byte_done;
    logic [7:0] rx_byte;
    logic [7:0] sum_next;
    logic       type_ok;
    logic       last_word;
    logic       timed_out;

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (bus.i_rx_data >= 8'h30 && bus.i_rx_data <= 8'h39)
            nib = bus.i_rx_data[3:0];
        else if ((bus.i_rx_data >= 8'h41 && bus.i_rx_data <= 8'h46) ||
                 (bus.i_rx_data >= 8'h61 && bus.i_rx_data <= 8'h66))
            nib = bus.i_rx_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    assign parse_state = (state == S_COUNT) || (state == S_ADDR) || (state == S_TYPE) ||
                         (state == S_DATA)  || (state == S_CSUM);
    assign rx_colon    = bus.i_rx_stb && (bus.i_rx_data == 8'h3A);
    assign bad_char    = bus.i_rx_stb && parse_state && !rx_colon && !is_hex;
    assign byte_done   = bus.i_rx_stb && parse_state && !rx_colon && is_hex && have_hi;
    assign rx_byte     = {hi_nib, nib};
    assign sum_next    = csum + rx_byte;
    assign last_word   = (word_idx == count[7:2] - 6'd1);
    assign timed_out   = (timer == TW'(WB_TIMEOUT - 1));

    always_comb begin
        case (rec_type)
            8'h00:   type_ok = (count[1:0] == 2'b00) && (int'(count) <= MAX_BYTES) &&
                               (rec_addr[1:0] == 2'b00);
            8'h01:   type_ok = (count == 8'd0);
            8'h04:   type_ok = (count == 8'd2);
            default: type_ok = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        resp_next  = CH_K;
        case (state)
            S_IDLE: if (rx_colon) state_next = S_COUNT;
            S_COUNT, S_ADDR, S_TYPE, S_DATA, S_CSUM: begin
                if (rx_colon) begin
                    state_next = S_COUNT;
                end else if (bad_char) begin
                    state_next = S_RESP;
                    resp_next  = CH_E;
                end else if (byte_done) begin
                    case (state)
                        S_COUNT: state_next = S_ADDR;
                        S_ADDR:  if (field_idx[0]) state_next = S_TYPE;
                        S_TYPE:  state_next = (count == 8'd0) ? S_CSUM : S_DATA;
                        S_DATA:  if (field_idx == count - 8'd1) state_next = S_CSUM;
                        default: begin
                            if (sum_next != 8'h00 || !type_ok) begin
                                state_next = S_RESP;
                                resp_next  = CH_E;
                            end else if (rec_type == 8'h00 && count != 8'd0) begin
                                state_next = S_WB_REQ;
                            end else begin
                                state_next = S_RESP;
                            end
                        end
                    endcase
                end
            end
            S_WB_REQ: begin
                if (!bus.i_mwb_stall) begin
                    state_next = S_WB_WAIT;
                end else if (timed_out) begin
                    state_next = S_RESP;
                    resp_next  = CH_T;
                end
            end
            S_WB_WAIT: begin
                if (bus.i_mwb_err) begin
                    state_next = S_RESP;
                    resp_next  = CH_W;
                end else if (bus.i_mwb_ack) begin
                    state_next = last_word ? S_RESP : S_WB_REQ;
                end else if (timed_out) begin
                    state_next = S_RESP;
                    resp_next  = CH_T;
                end
            end
            S_RESP:  if (!bus.i_tx_busy) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            csum      <= '0;
            ext_addr  <= '0;
            have_hi   <= 1'b0;
            hi_nib    <= '0;
            count     <= '0;
            rec_addr  <= '0;
            rec_type  <= '0;
            field_idx <= '0;
            word_idx  <= '0;
            timer     <= '0;
            data_buf  <= '0;
            resp_char <= '0;
            eof_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            eof_q     <= 1'b0;
            overrun_q <= bus.i_rx_stb && ((state == S_WB_REQ) || (state == S_WB_WAIT) ||
                                          (state == S_RESP));
            if (state != S_RESP) resp_char <= resp_next;

            if (rx_colon && (state == S_IDLE || parse_state)) begin
                csum      <= '0;
                have_hi   <= 1'b0;
                field_idx <= '0;
            end else if (bus.i_rx_stb && parse_state && is_hex) begin
                if (!have_hi) begin
                    hi_nib  <= nib;
                    have_hi <= 1'b1;
                end else begin
                    have_hi <= 1'b0;
                    csum    <= sum_next;
                    case (state)
                        S_COUNT: begin
                            count     <= rx_byte;
                            field_idx <= '0;
                        end
                        S_ADDR: begin
                            if (!field_idx[0]) rec_addr[15:8] <= rx_byte;
                            else               rec_addr[7:0]  <= rx_byte;
                            field_idx <= field_idx + 8'd1;
                        end
                        S_TYPE: begin
                            rec_type  <= rx_byte;
                            field_idx <= '0;
                        end
                        S_DATA: begin
                            // Bytes past MAX_BYTES are still counted and summed; the record fails validation.
                            if (int'(field_idx) < MAX_BYTES)
                                data_buf[{field_idx[BI-1:0], 3'b000} +: 8] <= rx_byte;
                            field_idx <= field_idx + 8'd1;
                        end
                        default: begin
                            if (sum_next == 8'h00 && type_ok) begin
                                if (rec_type == 8'h01) eof_q <= 1'b1;
                                if (rec_type == 8'h04) ext_addr <= {data_buf[7:0], data_buf[15:8]};
                            end
                        end
                    endcase
                end
            end

            // Timeout budget restarts for every word.
            if (state_next == S_WB_REQ && state != S_WB_REQ)
                timer <= '0;
            else if (state == S_WB_REQ || state == S_WB_WAIT)
                timer <= timer + TW'(1);

            if (state == S_CSUM)
                word_idx <= '0;
            else if (state == S_WB_WAIT && bus.i_mwb_ack && !bus.i_mwb_err)
                word_idx <= word_idx + 6'd1;
        end
    end

    always_comb begin
        bus.o_mwb_cyc  = (state == S_WB_REQ) || (state == S_WB_WAIT);
        bus.o_mwb_stb  = (state == S_WB_REQ);
        bus.o_mwb_we   = 1'b1;
        bus.o_mwb_sel  = 4'hF;
        bus.o_mwb_addr = '0;
        bus.o_mwb_data = '0;
        if (bus.o_mwb_cyc) begin
            bus.o_mwb_addr = {ext_addr, rec_addr[15:2]} + 30'(word_idx);
            bus.o_mwb_data = data_buf[{word_idx[WB-1:0], 5'b00000} +: 32];
        end
        bus.o_tx_stb   = (state == S_RESP) && !bus.i_tx_busy;
        bus.o_tx_data  = (state == S_RESP) ? resp_char : 8'h00;
        bus.o_eof      = eof_q;
        bus.o_overrun  = overrun_q;
        bus.dbg_state  = state;
    end
endmodule

// File: tb/tb_ihex_record_parser.sv
// Directed Intel-HEX records against ihex_record_parser with a scoreboard of expected
// status characters and Wishbone writes, checked by a negedge monitor.
module tb_ihex_record_parser;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    ihex_record_parser_if bus();

    ihex_record_parser dut (
        .i_clk     (clk),
        .i_reset_n (reset_n),
        .bus       (bus)
    );

    logic       rx_stb    = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       tx_busy   = 1'b0;
    logic       slv_stall = 1'b0;
    logic       slv_ack   = 1'b0;
    logic       slv_err   = 1'b0;

    assign bus.i_rx_stb    = rx_stb;
    assign bus.i_rx_data   = rx_data;
    assign bus.i_tx_busy   = tx_busy;
    assign bus.i_mwb_stall = slv_stall;
    assign bus.i_mwb_ack   = slv_ack;
    assign bus.i_mwb_err   = slv_err;

    logic [7:0]  tx_exp_q[$];
    logic [61:0] wb_exp_q[$];

    int checks = 0;
    int errors = 0;

    int stall_budget = 0;
    int no_ack       = 0;
    int err_word     = -1;
    int word_num     = 0;
    int pend         = 0;
    int pend_err     = 0;
    int eof_count    = 0;
    int overrun_cnt  = 0;
    int cyc_starts   = 0;
    int tx_count     = 0;
    logic prev_cyc   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor and Wishbone slave model.
    always @(negedge clk) begin
        logic accepted;
        logic [61:0] exp_wr;
        accepted = 1'b0;
        if (bus.o_eof) eof_count++;
        if (bus.o_overrun) overrun_cnt++;
        if (bus.o_mwb_cyc && !prev_cyc) cyc_starts++;
        prev_cyc = bus.o_mwb_cyc;

        if (bus.o_tx_stb) begin
            tx_count++;
            check("tx_while_busy", 64'(bus.i_tx_busy), 64'd0);
            if (tx_exp_q.size() == 0) begin
                check("unexpected_tx", 64'(bus.o_tx_data), 64'hff);
            end else begin
                check("tx_char", 64'(bus.o_tx_data), 64'(tx_exp_q.pop_front()));
            end
        end

        if (bus.o_mwb_stb && !bus.o_mwb_cyc) check("stb_without_cyc", 64'd1, 64'd0);

        if (bus.o_mwb_cyc && bus.o_mwb_stb) begin
            if (wb_exp_q.size() == 0) begin
                check("unexpected_wb_write", 64'(bus.o_mwb_addr), 64'h3fffffff);
            end else begin
                exp_wr = wb_exp_q[0];
                check("wb_addr", 64'(bus.o_mwb_addr), 64'(exp_wr[61:32]));
                check("wb_data", 64'(bus.o_mwb_data), 64'(exp_wr[31:0]));
                check("wb_we_sel", 64'({bus.o_mwb_we, bus.o_mwb_sel}), 64'h1f);
                if (!bus.i_mwb_stall) begin
                    void'(wb_exp_q.pop_front());
                    accepted = 1'b1;
                end
            end
        end

        slv_ack = 1'b0;
        slv_err = 1'b0;
        if (pend != 0) begin
            if (pend_err != 0) slv_err = 1'b1;
            else               slv_ack = 1'b1;
            pend = 0;
        end
        if (bus.o_mwb_cyc && bus.o_mwb_stb && bus.i_mwb_stall && stall_budget > 0)
            stall_budget--;
        if (accepted) begin
            if (no_ack == 0) begin
                pend     = 1;
                pend_err = (word_num == err_word) ? 1 : 0;
            end
            word_num++;
        end
        slv_stall = (stall_budget > 0);
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_stb  = 1'b1;
        rx_data = b;
        @(posedge clk); #1;
        rx_stb  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while ((tx_exp_q.size() != 0 || wb_exp_q.size() != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        check({name, "_drained"}, 64'(tx_exp_q.size() + wb_exp_q.size()), 64'd0);
        tx_exp_q.delete();
        wb_exp_q.delete();
        repeat (4) @(posedge clk);
    endtask

    function automatic logic [61:0] wr(input logic [29:0] a, input logic [31:0] d);
        return {a, d};
    endfunction

    initial begin
        int n;
        // Reset and reset-state checks.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc", 64'(bus.o_mwb_cyc), 64'd0);
        check("rst_stb", 64'(bus.o_mwb_stb), 64'd0);
        check("rst_we", 64'(bus.o_mwb_we), 64'd1);
        check("rst_sel", 64'(bus.o_mwb_sel), 64'hf);
        check("rst_tx_stb", 64'(bus.o_tx_stb), 64'd0);
        check("rst_eof_ovr", 64'({bus.o_eof, bus.o_overrun}), 64'd0);
        check("rst_state", 64'(bus.dbg_state), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic data record, CR/LF before the colon ignored.
        wb_exp_q.push_back(wr(30'h4, 32'h44332211));
        tx_exp_q.push_back(8'h4B);
        send_str("\r\n:040010001122334442");
        wait_idle("basic", 200);

        // Extended address then the same data record.
        tx_exp_q.push_back(8'h4B);
        send_str(":020000040800F2");
        wait_idle("ext", 200);
        wb_exp_q.push_back(wr(30'h02000004, 32'h44332211));
        tx_exp_q.push_back(8'h4B);
        send_str(":040010001122334442");
        wait_idle("ext_rec", 200);
        tx_exp_q.push_back(8'h4B);
        send_str(":020000040000FA");
        wait_idle("ext_clear", 200);

        // Bad checksum: 'E', no bus cycle.
        cyc_starts = 0;
        tx_exp_q.push_back(8'h45);
        send_str(":040010001122334443");
        wait_idle("bad_csum", 200);
        check("bad_csum_no_cyc", 64'(cyc_starts), 64'd0);

        // Validation failures: odd count, misaligned address, unknown type, non-hex.
        cyc_starts = 0;
        tx_exp_q.push_back(8'h45);
        send_str(":03000000010203F7");
        wait_idle("count3", 200);
        tx_exp_q.push_back(8'h45);
        send_str(":040012001122334440");
        wait_idle("misaligned", 200);
        tx_exp_q.push_back(8'h45);
        send_str(":020000020000FC");
        wait_idle("type02", 200);
        tx_exp_q.push_back(8'h45);
        send_str(":04G");
        wait_idle("nonhex", 200);
        check("invalid_no_cyc", 64'(cyc_starts), 64'd0);

        // Colon restart, then a count-0 data record: one 'K' only.
        tx_exp_q.push_back(8'h4B);
        send_str(":04:0000000000");
        wait_idle("restart", 200);

        // Lowercase hex digits.
        wb_exp_q.push_back(wr(30'h4, 32'hccbbaa11));
        tx_exp_q.push_back(8'h4B);
        send_str(":0400100011aabbccaa");
        wait_idle("lower", 200);

        // 8-byte record with 3 stall cycles on word 0: both words in one cycle.
        cyc_starts   = 0;
        stall_budget = 3;
        word_num     = 0;
        wb_exp_q.push_back(wr(30'h8, 32'h04030201));
        wb_exp_q.push_back(wr(30'h9, 32'h08070605));
        tx_exp_q.push_back(8'h4B);
        send_str(":080020000102030405060708B4");
        wait_idle("stall", 300);
        check("stall_one_cyc", 64'(cyc_starts), 64'd1);
        check("stall_budget_used", 64'(stall_budget), 64'd0);

        // Bus error on word 0: word 1 is never issued.
        word_num = 0;
        err_word = 0;
        wb_exp_q.push_back(wr(30'h8, 32'h04030201));
        tx_exp_q.push_back(8'h57);
        send_str(":080020000102030405060708B4");
        wait_idle("wb_err", 300);
        check("err_words_issued", 64'(word_num), 64'd1);
        err_word = -1;

        // End-of-file record.
        eof_count = 0;
        tx_exp_q.push_back(8'h4B);
        send_str(":00000001FF");
        wait_idle("eof", 200);
        check("eof_pulses", 64'(eof_count), 64'd1);

        // Transmitter busy for 5 cycles; a byte during RESP is an overrun.
        overrun_cnt = 0;
        tx_busy = 1'b1;
        tx_exp_q.push_back(8'h4B);
        send_str(":0000000000");
        send_byte(8'h58);
        repeat (5) @(posedge clk);
        check("busy_held_tx", 64'(tx_exp_q.size()), 64'd1);
        #1 tx_busy = 1'b0;
        wait_idle("busy", 200);
        check("overrun_pulses", 64'(overrun_cnt), 64'd1);

        // Missing ack: timeout reply.
        no_ack = 1;
        wb_exp_q.push_back(wr(30'h4, 32'h44332211));
        tx_exp_q.push_back(8'h54);
        send_str(":040010001122334442");
        wait_idle("timeout", 3000);
        no_ack = 0;

        // Reset while waiting for ack: cyc drops next cycle and no reply.
        no_ack = 1;
        wb_exp_q.push_back(wr(30'h4, 32'h44332211));
        send_str(":040010001122334442");
        n = 0;
        while (wb_exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("rst_mid_accepted", 64'(wb_exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_cyc_before", 64'(bus.o_mwb_cyc), 64'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_cyc_after", 64'(bus.o_mwb_cyc), 64'd0);
        reset_n = 1'b1;
        no_ack  = 0;
        tx_count = 0;
        repeat (20) @(posedge clk);
        check("rst_mid_no_tx", 64'(tx_count), 64'd0);
        wb_exp_q.push_back(wr(30'h4, 32'h44332211));
        tx_exp_q.push_back(8'h4B);
        send_str(":040010001122334442");
        wait_idle("after_rst", 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
